// File: rtl/rotate_right_sequencer.sv
// Command-level controller for an external free-running rotate-right register:
// loads command data, counts rotation clocks, captures and returns the result.
module rotate_right_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [AMT_W-1:0] i_cmd_amt,
    input  logic             i_abort,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_busy,
    output logic             o_reg_rst,
    output logic             o_reg_load,
    output logic [WIDTH-1:0] o_reg_din,
    input  logic [WIDTH-1:0] i_reg_dout
);

    typedef enum logic [1:0] {IDLE, LOAD, ROT, RESP} state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] din_q, din_nxt;
    logic [WIDTH-1:0] res_q, res_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            din_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            din_q <= din_nxt;
            res_q <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        din_nxt   = din_q;
        res_nxt   = res_q;
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    din_nxt   = i_cmd_data;
                    cnt_nxt   = i_cmd_amt;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (i_abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ROT;
                end
            end
            ROT: begin
                // Abort beats capture, so a dropped command never yields a result.
                if (i_abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    res_nxt   = i_reg_dout;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (i_res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register held in clear whenever no rotation is in progress.
    assign o_cmd_ready = (state == IDLE);
    assign o_res_valid = (state == RESP);
    assign o_busy      = (state != IDLE);
    assign o_reg_rst   = (state == IDLE) || (state == RESP);
    assign o_reg_load  = (state == LOAD);
    assign o_reg_din   = din_q;
    assign o_res_data  = res_q;

endmodule

// File: tb/tb_rotate_right_sequencer.sv
// Bench for rotate_right_sequencer: models the external rotate register,
// drives directed and random commands, checks against an arithmetic rotate.
module tb_rotate_right_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_cmd_valid = 1'b0;
    logic             o_cmd_ready;
    logic [WIDTH-1:0] i_cmd_data = '0;
    logic [AMT_W-1:0] i_cmd_amt = '0;
    logic             i_abort = 1'b0;
    logic             o_res_valid;
    logic             i_res_ready = 1'b1;
    logic [WIDTH-1:0] o_res_data;
    logic             o_busy;
    logic             o_reg_rst;
    logic             o_reg_load;
    logic [WIDTH-1:0] o_reg_din;
    logic [WIDTH-1:0] reg_q = '0;

    int total = 0;
    int bad   = 0;

    rotate_right_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_data (i_cmd_data),
        .i_cmd_amt  (i_cmd_amt),
        .i_abort    (i_abort),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_data (o_res_data),
        .o_busy     (o_busy),
        .o_reg_rst  (o_reg_rst),
        .o_reg_load (o_reg_load),
        .o_reg_din  (o_reg_din),
        .i_reg_dout (reg_q)
    );

    always #5 i_clk = ~i_clk;

    // External register: sync clear > load > rotate right by one.
    always @(posedge i_clk) begin
        if (o_reg_rst)       reg_q <= '0;
        else if (o_reg_load) reg_q <= o_reg_din;
        else                 reg_q <= {reg_q[0], reg_q[WIDTH-1:1]};
    end

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d, input int a);
        int unsigned x;
        x = d;
        return WIDTH'(((x >> a) | (x << (WIDTH - a))) & 32'hFFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one command; result is held unaccepted for `hold` cycles.
    task automatic run_cmd(input string tag, input logic [WIDTH-1:0] d,
                           input logic [AMT_W-1:0] a, input int hold);
        logic [WIDTH-1:0] exp;
        int n, loads;
        exp = rot(d, int'(a));
        chk({tag, ".rdy"}, o_cmd_ready, 1);
        i_res_ready = (hold == 0);
        i_cmd_valid = 1'b1;
        i_cmd_data  = d;
        i_cmd_amt   = a;
        step();
        i_cmd_valid = 1'b0;
        i_cmd_data  = WIDTH'($urandom);
        i_cmd_amt   = AMT_W'($urandom);
        chk({tag, ".din"}, o_reg_din, d);
        chk({tag, ".busy"}, o_busy, 1);
        loads = int'(o_reg_load);
        n = 0;
        while (!o_res_valid && n < 40) begin
            step();
            n++;
            loads += int'(o_reg_load);
        end
        chk({tag, ".lat"}, n, 2 + int'(a));
        chk({tag, ".loads"}, loads, 1);
        chk({tag, ".data"}, o_res_data, exp);
        for (int i = 0; i < hold; i++) begin
            i_abort = 1'($urandom);
            step();
            chk({tag, ".hvld"}, o_res_valid, 1);
            chk({tag, ".hdat"}, o_res_data, exp);
            chk({tag, ".hrdy"}, o_cmd_ready, 0);
            chk({tag, ".hrst"}, o_reg_rst, 1);
        end
        i_abort     = 1'b0;
        i_res_ready = 1'b1;
        step();
        chk({tag, ".pulse"}, o_res_valid, 0);
        chk({tag, ".idle"}, o_cmd_ready, 1);
        chk({tag, ".keep"}, o_res_data, exp);
    endtask

    initial begin
        int vcount;

        // Reset state, before any clock edge
        #2;
        chk("rst.rdy", o_cmd_ready, 1);
        chk("rst.vld", o_res_valid, 0);
        chk("rst.busy", o_busy, 0);
        chk("rst.regrst", o_reg_rst, 1);
        chk("rst.load", o_reg_load, 0);
        chk("rst.din", o_reg_din, 0);
        chk("rst.res", o_res_data, 0);
        step();
        step();
        i_rst_n = 1'b1;
        step();

        // Directed cases
        run_cmd("t1", 16'h0001, 4'd1, 0);
        run_cmd("t2a", 16'h1234, 4'd4, 0);
        run_cmd("t2b", 16'h8001, 4'd15, 0);
        run_cmd("t3", 16'hA5A5, 4'd0, 0);
        run_cmd("t4", 16'h0F0F, 4'd3, 5);

        // Abort two cycles into ROT
        i_cmd_valid = 1'b1;
        i_cmd_data  = 16'hBEEF;
        i_cmd_amt   = 4'd10;
        step();
        i_cmd_valid = 1'b0;
        step();
        step();
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("t5.rdy", o_cmd_ready, 1);
        chk("t5.busy", o_busy, 0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            vcount += int'(o_res_valid);
            step();
        end
        chk("t5.novld", vcount, 0);
        run_cmd("t5n", 16'h00F0, 4'd4, 0);

        // Asynchronous reset mid-ROT
        i_cmd_valid = 1'b1;
        i_cmd_data  = 16'h1357;
        i_cmd_amt   = 4'd8;
        step();
        i_cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("t6.pre", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("t6.rdy", o_cmd_ready, 1);
        chk("t6.vld", o_res_valid, 0);
        chk("t6.busy", o_busy, 0);
        chk("t6.regrst", o_reg_rst, 1);
        chk("t6.load", o_reg_load, 0);
        chk("t6.din", o_reg_din, 0);
        chk("t6.res", o_res_data, 0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("t6.rdy2", o_cmd_ready, 1);
        chk("t6.regrst2", o_reg_rst, 1);
        run_cmd("t6n", 16'hC001, 4'd2, 1);

        // Random commands with random back-pressure and idle gaps
        for (int k = 0; k < 24; k++) begin
            run_cmd("rnd", WIDTH'($urandom), AMT_W'($urandom_range(0, WIDTH - 1)),
                    int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
